// File: rtl/soc_map_pkg.sv
// rtl/soc_map_pkg.sv - SoC address map constants shared by the data-SRAM responder
package soc_map_pkg;

    localparam logic [31:0] DEF_RAM_BASE  = 32'h1c00_0000;
    localparam logic [31:0] DEF_MMIO_BASE = 32'hbfaf_0000;

    localparam logic [15:0] OFF_LED    = 16'hF000;
    localparam logic [15:0] OFF_NUM    = 16'hF004;
    localparam logic [15:0] OFF_SWITCH = 16'hF008;
    localparam logic [15:0] OFF_TIMER  = 16'hE000;
    localparam logic [15:0] OFF_WRCNT  = 16'hF010;

    localparam logic [15:0] LED_RESET  = 16'hFFFF;

endpackage

// File: rtl/sram_word_array.sv
// rtl/sram_word_array.sv - word RAM, one clocked write port, one asynchronous read port
module sram_word_array #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Store the full word on the edge; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_sram_rsp.sv
// rtl/data_sram_rsp.sv - data-SRAM responder: RAM window plus MMIO registers (timer under DATA_SRAM_RSP_TIMER_EN)
module data_sram_rsp
    import soc_map_pkg::*;
#(
    parameter int          RAM_AW    = 16,
    parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
    parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out,
    output logic        bad_access
);

    localparam int TAG_LSB = RAM_AW + 2;

    logic        ram_hit;
    logic        mmio_hit;
    logic        miss;
    logic [13:0] reg_word;
    logic        sel_led;
    logic        sel_num;
    logic        sel_switch;
    logic        sel_wrcnt;
    logic        ram_we;
    logic        led_we;
    logic        num_we;
    logic        timer_we;
    logic        wr_accept;
    logic [31:0] ram_rdata;
    logic [31:0] timer_val;

    logic [15:0] led_q;
    logic [31:0] num_q;
    logic [31:0] wrcnt_q;
    logic        bad_q;
    logic [7:0]  sync1_q;
    logic [7:0]  sync2_q;

    // Byte-lane bits are irrelevant: every access is a full word.
    logic unused_byte_lane;
    assign unused_byte_lane = ^data_sram_addr[1:0];

    assign ram_hit  = (data_sram_addr[31:TAG_LSB] == RAM_BASE[31:TAG_LSB]);
    assign mmio_hit = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign miss     = !ram_hit && !mmio_hit;
    assign reg_word = data_sram_addr[15:2];

    assign sel_led    = mmio_hit && (reg_word == OFF_LED[15:2]);
    assign sel_num    = mmio_hit && (reg_word == OFF_NUM[15:2]);
    assign sel_switch = mmio_hit && (reg_word == OFF_SWITCH[15:2]);
    assign sel_wrcnt  = mmio_hit && (reg_word == OFF_WRCNT[15:2]);

    assign ram_we    = data_sram_we && ram_hit;
    assign led_we    = data_sram_we && sel_led;
    assign num_we    = data_sram_we && sel_num;
    assign wr_accept = ram_we || led_we || num_we || timer_we;

    sram_word_array #(
        .AW(RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (data_sram_addr[RAM_AW+1:2]),
        .wdata (data_sram_wdata),
        .rdata (ram_rdata)
    );

`ifdef DATA_SRAM_RSP_TIMER_EN
    logic        sel_timer;
    logic [31:0] timer_q;

    assign sel_timer = mmio_hit && (reg_word == OFF_TIMER[15:2]);
    assign timer_we  = data_sram_we && sel_timer;
    assign timer_val = sel_timer ? timer_q : 32'h0;

    // Free-running counter; a CPU store loads it and wins over the increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= 32'h0;
        end else if (timer_we) begin
            timer_q <= data_sram_wdata;
        end else begin
            timer_q <= timer_q + 32'h1;
        end
    end
`else
    assign timer_we  = 1'b0;
    assign timer_val = 32'h0;
`endif

    // Software-visible registers, store counter and sticky miss flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q   <= LED_RESET;
            num_q   <= 32'h0;
            wrcnt_q <= 32'h0;
            bad_q   <= 1'b0;
        end else begin
            if (led_we) begin
                led_q <= data_sram_wdata[15:0];
            end
            if (num_we) begin
                num_q <= data_sram_wdata;
            end
            if (wr_accept) begin
                wrcnt_q <= wrcnt_q + 32'h1;
            end
            if (miss) begin
                bad_q <= 1'b1;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 8'h0;
            sync2_q <= 8'h0;
        end else begin
            sync1_q <= switch_in;
            sync2_q <= sync1_q;
        end
    end

    // Same-cycle read mux; misses and unmapped offsets read as zero.
    always_comb begin
        data_sram_rdata = 32'h0;
        if (ram_hit) begin
            data_sram_rdata = ram_rdata;
        end else if (sel_led) begin
            data_sram_rdata = {16'h0, led_q};
        end else if (sel_num) begin
            data_sram_rdata = num_q;
        end else if (sel_switch) begin
            data_sram_rdata = {24'h0, sync2_q};
        end else if (sel_wrcnt) begin
            data_sram_rdata = wrcnt_q;
        end else begin
            data_sram_rdata = timer_val;
        end
    end

    assign led_out    = led_q;
    assign num_out    = num_q;
    assign bad_access = bad_q;

endmodule

// File: tb/tb_data_sram_rsp.sv
// tb/tb_data_sram_rsp.sv - randomized self-checking bench for data_sram_rsp
module tb_data_sram_rsp;

    logic        clk = 1'b0;
    logic        resetn;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  sw;
    logic [15:0] led;
    logic [31:0] num;
    logic        bad;

`ifdef DATA_SRAM_RSP_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    data_sram_rsp dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch_in       (sw),
        .led_out         (led),
        .num_out         (num),
        .bad_access      (bad)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_ram [int unsigned];
    logic [15:0] m_led;
    logic [31:0] m_num;
    logic [31:0] m_timer;
    logic [31:0] m_wrcnt;
    logic [7:0]  m_s1;
    logic [7:0]  m_s2;
    logic        m_bad;
    logic [31:0] rd_seen;

    function automatic bit in_ram(input logic [31:0] a);
        return (a >= 32'h1c00_0000) && (a < 32'h1c04_0000);
    endfunction

    function automatic bit in_mmio(input logic [31:0] a);
        return (a >= 32'hbfaf_0000) && (a <= 32'hbfaf_ffff);
    endfunction

    function automatic int unsigned word_of(input logic [31:0] a);
        return (a - 32'h1c00_0000) / 4;
    endfunction

    function automatic logic [31:0] reg_off(input logic [31:0] a);
        return (a - 32'hbfaf_0000) & ~32'h3;
    endfunction

    function automatic bit exp_known(input logic [31:0] a);
        if (in_ram(a)) return m_ram.exists(word_of(a));
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (in_ram(a)) begin
            if (m_ram.exists(word_of(a))) return m_ram[word_of(a)];
            return 32'h0;
        end
        if (in_mmio(a)) begin
            case (reg_off(a))
                32'hf000: return {16'h0, m_led};
                32'hf004: return m_num;
                32'hf008: return {24'h0, m_s2};
                32'he000: return TIMER_EN ? m_timer : 32'h0;
                32'hf010: return m_wrcnt;
                default:  return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_led   = 16'hFFFF;
        m_num   = 32'h0;
        m_timer = 32'h0;
        m_wrcnt = 32'h0;
        m_s1    = 8'h0;
        m_s2    = 8'h0;
        m_bad   = 1'b0;
    endtask

    task automatic model_edge(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
        logic [31:0] next_timer;
        next_timer = m_timer + 32'h1;
        if (w && in_ram(a)) begin
            m_ram[word_of(a)] = d;
            m_wrcnt = m_wrcnt + 32'h1;
        end else if (w && in_mmio(a)) begin
            case (reg_off(a))
                32'hf000: begin m_led = d[15:0]; m_wrcnt = m_wrcnt + 32'h1; end
                32'hf004: begin m_num = d;       m_wrcnt = m_wrcnt + 32'h1; end
                32'he000: if (TIMER_EN) begin next_timer = d; m_wrcnt = m_wrcnt + 32'h1; end
                default: ;
            endcase
        end
        if (!in_ram(a) && !in_mmio(a)) m_bad = 1'b1;
        m_timer = TIMER_EN ? next_timer : 32'h0;
        m_s2 = m_s1;
        m_s1 = s;
    endtask

    // One bus cycle: drive at edge+1, sample mid-cycle, advance the model at the edge.
    task automatic cycle(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
        we = w;
        addr = a;
        wdata = d;
        sw = s;
        #3;
        rd_seen = rdata;
        if (exp_known(a)) check("rdata", rdata, exp_read(a));
        check("led_out", {16'h0, led}, {16'h0, m_led});
        check("num_out", num, m_num);
        check("bad_access", {31'h0, bad}, {31'h0, m_bad});
        @(posedge clk);
        if (resetn) model_edge(w, a, d, s);
        #1;
    endtask

    logic [31:0] cnt_a;
    logic [31:0] offs [7];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        offs = '{32'hf000, 32'hf004, 32'hf008, 32'he000, 32'hf010, 32'hf00c, 32'h0100};
        resetn = 1'b1;
        we = 1'b0;
        addr = 32'hbfaf_f008;
        wdata = 32'h0;
        sw = 8'hA5;
        #1 resetn = 1'b0;
        #1;
        check("rst_led", {16'h0, led}, 32'h0000_FFFF);
        check("rst_num", num, 32'h0);
        check("rst_bad", {31'h0, bad}, 32'h0);
        check("rst_switch", rdata, 32'h0);
        addr = 32'hbfaf_e000;
        #1 check("rst_timer", rdata, 32'h0);
        addr = 32'hbfaf_f010;
        #1 check("rst_wrcnt", rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        sw = 8'h0;
        resetn = 1'b1;

        // RAM write/read, same-cycle read, byte-offset alias
        cycle(1, 32'h1c00_0010, 32'h1234_5678, 8'h0);
        cycle(0, 32'h1c00_0010, 32'h0, 8'h0);
        check("ram_next", rd_seen, 32'h1234_5678);
        cycle(0, 32'h1c00_0013, 32'h0, 8'h0);
        check("ram_alias", rd_seen, 32'h1234_5678);
        cycle(1, 32'h1c00_0010, 32'hCAFE_F00D, 8'h0);
        check("ram_same_cycle", rd_seen, 32'h1234_5678);
        cycle(0, 32'h1c00_0010, 32'h0, 8'h0);
        check("ram_new", rd_seen, 32'hCAFE_F00D);

        // LED and NUM registers
        cycle(1, 32'hbfaf_f000, 32'h0000_00A5, 8'h0);
        check("led_a5", {16'h0, led}, 32'h0000_00A5);
        cycle(1, 32'hbfaf_f004, 32'hDEAD_BEEF, 8'h0);
        check("num_val", num, 32'hDEAD_BEEF);
        cycle(0, 32'hbfaf_f004, 32'h0, 8'h0);
        check("num_rd", rd_seen, 32'hDEAD_BEEF);

        // Switch synchronizer: visible from the second edge
        cycle(0, 32'hbfaf_f008, 32'h0, 8'h3C);
        check("sw_e0", rd_seen, 32'h0);
        cycle(0, 32'hbfaf_f008, 32'h0, 8'h3C);
        check("sw_e1", rd_seen, 32'h0);
        cycle(0, 32'hbfaf_f008, 32'h0, 8'h3C);
        check("sw_e2", rd_seen, 32'h0000_003C);

        // Timer load and wrap; WRCNT counts the store only with the timer present
        cycle(0, 32'hbfaf_f010, 32'h0, 8'h3C);
        cnt_a = rd_seen;
        cycle(1, 32'hbfaf_e000, 32'hFFFF_FFFE, 8'h3C);
        cycle(0, 32'hbfaf_e000, 32'h0, 8'h3C);
        check("tmr0", rd_seen, TIMER_EN ? 32'hFFFF_FFFE : 32'h0);
        cycle(0, 32'hbfaf_e000, 32'h0, 8'h3C);
        check("tmr1", rd_seen, TIMER_EN ? 32'hFFFF_FFFF : 32'h0);
        cycle(0, 32'hbfaf_e000, 32'h0, 8'h3C);
        check("tmr2", rd_seen, 32'h0);
        cycle(0, 32'hbfaf_f010, 32'h0, 8'h3C);
        check("wrcnt_tmr", rd_seen, cnt_a + (TIMER_EN ? 32'h1 : 32'h0));

        // Randomized traffic inside both windows
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) < 4)
                a = 32'h1c00_0100 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            else
                a = 32'hbfaf_0000 + offs[$urandom_range(0, 6)] + $urandom_range(0, 3);
            cycle(1'($urandom_range(0, 1)), a, $urandom, 8'($urandom));
        end

        // Asynchronous reset in the middle of writes
        cycle(1, 32'hbfaf_f000, 32'h0000_1234, 8'h11);
        we = 1'b1;
        addr = 32'hbfaf_f004;
        wdata = 32'h5555_5555;
        resetn = 1'b0;
        #2;
        check("mid_rst_led", {16'h0, led}, 32'h0000_FFFF);
        check("mid_rst_num", num, 32'h0);
        check("mid_rst_bad", {31'h0, bad}, 32'h0);
        check("mid_rst_rd", rdata, 32'h0);
        addr = 32'hbfaf_f010;
        #1 check("mid_rst_wrcnt", rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        we = 1'b0;
        resetn = 1'b1;
        cycle(0, 32'hbfaf_e000, 32'h0, 8'h0);
        check("post_rst_tmr", rd_seen, 32'h0);
        cycle(0, 32'h1c00_0010, 32'h0, 8'h0);
        check("ram_retained", rd_seen, 32'hCAFE_F00D);
        cycle(0, 32'hbfaf_f004, 32'h0, 8'h0);
        check("lost_write", rd_seen, 32'h0);

        // Miss: zero read data, sticky flag, dropped write
        cycle(0, 32'hbfaf_f010, 32'h0, 8'h0);
        cnt_a = rd_seen;
        cycle(0, 32'h0000_1000, 32'h0, 8'h0);
        check("miss_rd", rd_seen, 32'h0);
        check("miss_bad", {31'h0, bad}, 32'h1);
        cycle(1, 32'h0000_1000, 32'hFFFF_FFFF, 8'h0);
        cycle(0, 32'hbfaf_f010, 32'h0, 8'h0);
        check("miss_wrcnt", rd_seen, cnt_a);
        check("bad_sticky", {31'h0, bad}, 32'h1);
        cycle(0, 32'h1c00_0010, 32'h0, 8'h0);
        check("miss_ram", rd_seen, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_rsp.md
# data_sram_rsp

Responder end of the CPU data-SRAM interface: it accepts the single-cycle core's `data_sram_*` requests and serves them. It decodes each request into an on-chip word RAM window or a small memory-mapped register window (LED, number display, switches, free-running timer) and returns read data combinationally in the same cycle. The block sits beside the core in the SoC top, replacing a bare RAM so that the trace bench and board I/O both see CPU stores.

## Interface
- `RAM_AW`, 16: word-address bits of the RAM window (2^RAM_AW words).
- `RAM_BASE`, 32'h1c00_0000: byte base of the RAM window, aligned to 2^(RAM_AW+2).
- `MMIO_BASE`, 32'hbfaf_0000: byte base of the 64 KiB register window.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `data_sram_we`  in  1  write strobe (already qualified by core `valid`).
- `data_sram_addr`  in  32  byte address; bits [1:0] ignored.
- `data_sram_wdata`  in  32  write data, full word.
- `data_sram_rdata`  out  32  read data for `data_sram_addr`, combinational.
- `switch_in`  in  8  board switches, sampled through a 2-flop synchronizer.
- `led_out`  out  16  LED register.
- `num_out`  out  32  number-display register.
- `bad_access`  out  1  sticky flag: an access hit neither window.

## Operation
- Decode: RAM hit when `addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]`; MMIO hit when `addr[31:16] == MMIO_BASE[31:16]`; otherwise miss.
- RAM: word index `addr[RAM_AW+1:2]`; write stores `wdata` at the edge; read is asynchronous. Contents are not reset.
- MMIO offsets (`addr[15:0]`):
  - 0xF000 LED: RW, low 16 bits; reset 16'hFFFF.
  - 0xF004 NUM: RW, 32 bits; reset 0.
  - 0xF008 SWITCH: RO, {24'b0, synchronized switches}; writes ignored.
  - 0xE000 TIMER: RW 32-bit counter.
  - 0xF010 WRCNT: RO count of accepted writes (RAM + MMIO), wraps 2^32-1 → 0.
  - Any other offset reads 0; writes dropped, not counted.
- Miss: read returns 0; write dropped; either sets `bad_access` (evaluated every cycle, since reads are not strobed). Only reset clears it.
- Reset values: `data_sram_rdata` reflects decode of current address (registers at reset values); `led_out`=16'hFFFF, `num_out`=0, `bad_access`=0, timer=0, WRCNT=0, synchronizer=0.

## Timing
- Read latency 0: `rdata` valid in the same cycle as `addr`, as required by the single-cycle core.
- Write latency 1: visible to reads from the cycle after the edge; a same-cycle read of the written address returns the old value.
- Timer: +1 every cycle after reset release, wraps 32'hFFFF_FFFF → 0. A timer write loads `wdata` at that edge (write wins over increment); counting resumes the next cycle.
- SWITCH read reflects `switch_in` two edges later.
- Reset assertion mid-operation clears all registers immediately (async); a write in that cycle is lost. Deassertion is synchronized by the instantiating top; no extra handling here.

## Configuration
- `DATA_SRAM_RSP_TIMER_EN`: defined → TIMER register implemented as above. Undefined → no counter flops; offset 0xE000 reads 0 and writes are dropped and not counted in WRCNT.

## Structure
- Shared package `soc_map_pkg`: `RAM_BASE`/`MMIO_BASE` defaults, MMIO offset constants (`OFF_LED`, `OFF_NUM`, `OFF_SWITCH`, `OFF_TIMER`, `OFF_WRCNT`), LED reset constant.
- One sub-module `sram_word_array` (parameter `AW`; one write port on `clk`, one async read port); decode, registers, counters, synchronizer stay in the top.

## Test plan
- Write 0x1234_5678 to 0x1c00_0010, next cycle read 0x1c00_0010 → 0x1234_5678; same-cycle read during write → prior contents; read 0x1c00_0013 → same word.
- Write 0x0000_00A5 to 0xbfaf_f000 → `led_out`=16'h00A5; write 0xDEAD_BEEF to 0xbfaf_f004 → `num_out`=0xDEAD_BEEF, readback matches.
- Drive `switch_in`=8'h3C → read 0xbfaf_f008 returns 0x0000_003C from the second edge on; before that, old value.
- Timer (macro on): write 0xFFFF_FFFE to 0xbfaf_e000 → reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on successive cycles. Macro off: read returns 0, WRCNT unchanged by the write.
- Read then write 0x0000_1000 (miss) → rdata 0, `bad_access`=1 and stays 1; RAM/regs unchanged; WRCNT unchanged.
- Assert `resetn`=0 mid-sequence of writes → `led_out`=16'hFFFF, `num_out`=0, `bad_access`=0, timer and WRCNT 0 without a clock edge; RAM data retained.
